// File: rtl/hram_pkg.sv
// Shared types and constants for the HyperRAM transaction sequencer.
package hram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CSLO,
        CA,
        LAT,
        WR,
        RD,
        CSHI
    } state_e;

    localparam int CA_RW    = 47;
    localparam int CA_AS    = 46;
    localparam int CA_BURST = 45;
    localparam int CA_BYTES = 6;
    localparam int CSHI_CYC = 2;

    // 48-bit command/address word: linear burst, memory space, row in [44:16], column in [2:0].
    function automatic logic [47:0] ca_word(input logic write, input logic [28:0] row,
                                            input logic [2:0] col);
        ca_word           = '0;
        ca_word[CA_RW]    = !write;
        ca_word[CA_AS]    = 1'b0;
        ca_word[CA_BURST] = 1'b1;
        ca_word[44:16]    = row;
        ca_word[2:0]      = col;
    endfunction

endpackage

// File: rtl/hram_seq_if.sv
// Command, write-stream and read-stream bundle between a requester and hram_seq.
interface hram_seq_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [7:0]        wr_data;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              busy;
    logic              err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, err
    );
endinterface

// File: rtl/hram_rd_capture.sv
// Registers RWDS/DQ from the pads and turns each RWDS level change into one read byte.
module hram_rd_capture (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rwds_din,
    input  logic [7:0] dq_din,
    output logic       rwds_q,
    output logic       cap,
    output logic       rd_valid,
    output logic [7:0] rd_data
);
    logic       rwds_q2;
    logic [7:0] dq_q;

    // Either RWDS edge marks a byte; only honoured while the sequencer is reading.
    assign cap = en && (rwds_q != rwds_q2);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the data registers are reset as well, so rd_data is defined from the first cycle.
        if (reset) begin
            rwds_q   <= 1'b0;
            rwds_q2  <= 1'b0;
            dq_q     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rwds_q   <= rwds_din;
            rwds_q2  <= rwds_q;
            dq_q     <= dq_din;
            rd_valid <= cap;
            if (cap) rd_data <= dq_q;
        end
    end
endmodule

// File: rtl/hram_seq.sv
// HyperRAM transaction sequencer: emits one pin word {ck,cs,dirs,dq} per clk for each burst.
// Optional read watchdog (err flag) is built when HRAM_SEQ_TIMEOUT_EN is defined.
module hram_seq
    import hram_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int LATENCY = 6,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    hram_seq_if.slave  bus,
    output logic       hram_ck,
    output logic       hram_cs,
    output logic       hram_rwds_dir,
    output logic       hram_rwds_dout,
    output logic       hram_dq_dir,
    output logic [7:0] hram_dq_dout,
    input  logic       hram_rwds_din,
    input  logic [7:0] hram_dq_din
);
    localparam int LAT_MAX = (4 * LATENCY > CA_BYTES) ? 4 * LATENCY : CA_BYTES;
    localparam int CNT_MAX = (LAT_MAX > TIMEOUT) ? LAT_MAX : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, lat_last;
    logic [LEN_W:0]    byte_q, byte_d, last_byte;
    logic              ck_q, ck_d, ready_q, write_q, dbl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              rwds_q, cap, accept;
    logic [47:0]       ca_w, ca_sh;

    assign accept    = bus.cmd_valid && ready_q;
    assign last_byte = {len_q, 1'b1};
    assign lat_last  = dbl_q ? CNT_W'(4 * LATENCY - 1) : CNT_W'(2 * LATENCY - 1);
    assign ca_w      = ca_word(write_q, 29'(addr_q >> 3), addr_q[2:0]);
    assign ca_sh     = ca_w << (8 * cnt_q);

`ifdef HRAM_SEQ_TIMEOUT_EN
    logic timeout, err_q;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        ck_d    = 1'b0;
`ifdef HRAM_SEQ_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) begin
                state_d = CSLO;
                cnt_d   = '0;
            end
            CSLO: state_d = CA;
            CA: begin
                ck_d = ~ck_q;
                if (cnt_q == CNT_W'(CA_BYTES - 1)) begin
                    state_d = LAT;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            LAT: begin
                ck_d = ~ck_q;
                if (cnt_q == lat_last) begin
                    state_d = write_q ? WR : RD;
                    cnt_d   = '0;
                    byte_d  = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            WR: begin
                // A missing write byte holds ck so the memory never sees an edge for it.
                ck_d = bus.wr_valid ? ~ck_q : ck_q;
                if (bus.wr_valid) begin
                    if (byte_q == last_byte) state_d = CSHI;
                    else byte_d = byte_q + 1'b1;
                end
            end
            RD: begin
                ck_d = ~ck_q;
                if (cap) begin
                    cnt_d = '0;
                    if (byte_q == last_byte) state_d = CSHI;
                    else byte_d = byte_q + 1'b1;
                end
`ifdef HRAM_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = CSHI;
                    cnt_d   = '0;
                    timeout = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
`endif
            end
            CSHI: begin
                if (cnt_q == CNT_W'(CSHI_CYC - 1)) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == CSHI || state_d == IDLE) ck_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            ck_q    <= 1'b0;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            dbl_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            ck_q    <= ck_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                addr_q  <= bus.cmd_addr;
                write_q <= bus.cmd_write;
                len_q   <= bus.cmd_len;
            end
            // The memory flags a refresh collision on RWDS during the third CA byte.
            if (state_q == CA && cnt_q == CNT_W'(2)) dbl_q <= rwds_q;
        end
    end

`ifdef HRAM_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        hram_cs        = 1'b1;
        hram_rwds_dir  = 1'b0;
        hram_rwds_dout = 1'b0;
        hram_dq_dir    = 1'b0;
        hram_dq_dout   = '0;
        case (state_q)
            CSLO: begin
                hram_cs     = 1'b0;
                hram_dq_dir = 1'b1;
            end
            CA: begin
                hram_cs      = 1'b0;
                hram_dq_dir  = 1'b1;
                hram_dq_dout = ca_sh[47:40];
            end
            LAT, RD: hram_cs = 1'b0;
            WR: begin
                hram_cs       = 1'b0;
                hram_rwds_dir = 1'b1;
                hram_dq_dir   = 1'b1;
                hram_dq_dout  = bus.wr_data;
            end
            default: ;
        endcase
    end

    assign hram_ck       = ck_q;
    assign bus.cmd_ready = ready_q;
    assign bus.wr_ready  = (state_q == WR);
    assign bus.busy      = (state_q != IDLE);

    hram_rd_capture u_capture (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == RD),
        .rwds_din (hram_rwds_din),
        .dq_din   (hram_dq_din),
        .rwds_q   (rwds_q),
        .cap      (cap),
        .rd_valid (bus.rd_valid),
        .rd_data  (bus.rd_data)
    );
endmodule

// File: tb/tb_hram_seq.sv
// Self-checking bench for hram_seq: behavioural HyperRAM model plus directed and random bursts.
module tb_hram_seq;
    localparam int LATENCY = 6;
    localparam int TIMEOUT = 255;
    localparam int CA_N    = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       hram_ck, hram_cs, hram_rwds_dir, hram_rwds_dout, hram_dq_dir;
    logic [7:0] hram_dq_dout;
    logic       hram_rwds_din;
    logic [7:0] hram_dq_din;

    int total;
    int bad;
    logic [7:0] data_q[$];

    hram_seq_if #(.ADDR_W(32), .LEN_W(8)) bus ();

    hram_seq #(.ADDR_W(32), .LEN_W(8), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .hram_ck        (hram_ck),
        .hram_cs        (hram_cs),
        .hram_rwds_dir  (hram_rwds_dir),
        .hram_rwds_dout (hram_rwds_dout),
        .hram_dq_dir    (hram_dq_dir),
        .hram_dq_dout   (hram_dq_dout),
        .hram_rwds_din  (hram_rwds_din),
        .hram_dq_din    (hram_dq_din)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command/address byte i as the memory expects it, straight from the bit layout.
    function automatic logic [7:0] exp_ca(input bit w, input logic [31:0] addr, input int i);
        logic [47:0] ca;
        ca = (48'(!w) << 47) | (48'd1 << 45) | ((48'(addr) >> 3) << 16) | 48'(addr & 32'd7);
        return ca[47 - 8 * i -: 8];
    endfunction

    task automatic fill(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
    endtask

    // One burst with the memory model answering on the pins; abort_after>0 resets mid-read.
    task automatic run_txn(input bit w, input logic [31:0] addr, input int len, input bit dbl,
                           input int stall_at, input int stall_len, input int abort_after,
                           input bit mute);
        int lat, nbytes, k0, k, n, ridx, gap, stall_rem, lat_cnt, toggles, frozen, rd_cyc;
        int pin_bad, n_rv;
        bit done;
        logic prev_ck, prev_rdir;
        logic [7:0] ca_got[$];
        logic [7:0] wsent[$];
        logic [7:0] rgot[$];

        lat    = dbl ? 4 * LATENCY : 2 * LATENCY;
        nbytes = 2 * (len + 1);
        k0     = 1 + CA_N + lat;

        bus.cmd_write = w;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 8'(len);
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("busy_rise", {bus.busy, bus.cmd_ready}, 2'b10);

        k = 0; ridx = 0; gap = $urandom_range(0, 2); stall_rem = stall_len;
        lat_cnt = 0; toggles = 0; frozen = 0; rd_cyc = 0; pin_bad = 0; done = 1'b0;
        prev_ck = 1'b0; prev_rdir = 1'b0;
        while (k < 3000) begin
            // Memory model: RWDS flags doubled latency during CA, then strobes read bytes.
            if (k <= CA_N) hram_rwds_din = dbl;
            else if (w || k < k0) hram_rwds_din = 1'b0;
            else if (!mute && ridx < data_q.size()) begin
                if (gap > 0) begin
                    gap--;
                    hram_dq_din = 8'($urandom);
                end else begin
                    hram_dq_din   = data_q[ridx];
                    hram_rwds_din = ~hram_rwds_din;
                    ridx++;
                    gap = $urandom_range(0, 2);
                end
            end else hram_dq_din = 8'($urandom);

            bus.wr_valid = 1'b0;
            if (bus.wr_ready) begin
                if (wsent.size() == stall_at && stall_rem > 0) stall_rem--;
                else if (wsent.size() < data_q.size()) begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = data_q[wsent.size()];
                end
            end
            #1;
            if (k >= 1 && k <= CA_N && !hram_cs && hram_dq_dir) ca_got.push_back(hram_dq_dout);
            if (w && !hram_cs && !hram_dq_dir && !hram_rwds_dir) lat_cnt++;
            if (!w && k >= k0 && !hram_cs) rd_cyc++;
            if (k > 0 && hram_ck !== prev_ck) toggles++;
            if (hram_rwds_dir && prev_rdir && hram_ck === prev_ck) frozen++;
            if (bus.wr_valid && bus.wr_ready) begin
                wsent.push_back(hram_dq_dout);
                if (!hram_rwds_dir || hram_rwds_dout || !hram_dq_dir || hram_cs) pin_bad++;
            end
            if (bus.rd_valid) rgot.push_back(bus.rd_data);
            prev_ck   = hram_ck;
            prev_rdir = hram_rwds_dir;

            if (abort_after > 0 && rgot.size() == abort_after) begin
                reset = 1'b1;
                #1;
                check("rst_cs", hram_cs, 1);
                check("rst_ck", hram_ck, 0);
                check("rst_dq_dir", hram_dq_dir, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_rd_valid", bus.rd_valid, 0);
                check("rst_cmd_ready", bus.cmd_ready, 0);
                n_rv = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (i == 2) reset = 1'b0;
                    hram_rwds_din = ~hram_rwds_din;
                    hram_dq_din   = 8'($urandom);
                    #1;
                    if (bus.rd_valid) n_rv++;
                end
                check("rst_no_rd_valid", n_rv, 0);
                check("rst_ready_after", bus.cmd_ready, 1);
                return;
            end
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end
        bus.wr_valid = 1'b0;

        check("txn_done", done, 1);
        check("ca_count", ca_got.size(), CA_N);
        for (int i = 0; i < CA_N; i++)
            check($sformatf("ca_byte%0d", i), (i < ca_got.size()) ? ca_got[i] : 8'hxx,
                  exp_ca(w, addr, i));
        check("cs_end", hram_cs, 1);
        if (w) begin
            check("lat_cycles", lat_cnt, lat);
            check("wr_count", wsent.size(), nbytes);
            for (int i = 0; i < nbytes && i < wsent.size(); i++)
                check($sformatf("wr_byte%0d", i), wsent[i], data_q[i]);
            check("wr_pins", pin_bad, 0);
            check("ck_toggles", toggles, CA_N + lat + nbytes);
            check("ck_frozen", frozen, stall_len);
        end else if (mute) begin
            check("to_rd_cycles", rd_cyc, TIMEOUT);
            check("to_err", bus.err, 1);
            check("to_no_rd_valid", rgot.size(), 0);
        end else begin
            check("rd_count", rgot.size(), nbytes);
            for (int i = 0; i < nbytes && i < rgot.size(); i++)
                check($sformatf("rd_byte%0d", i), rgot[i], data_q[i]);
            check("err_clear", bus.err, 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        hram_rwds_din = 1'b0;
        hram_dq_din   = '0;

        repeat (2) @(negedge clk);
        check("rst_ck0", hram_ck, 0);
        check("rst_cs0", hram_cs, 1);
        check("rst_rwds_dir0", hram_rwds_dir, 0);
        check("rst_rwds_dout0", hram_rwds_dout, 0);
        check("rst_dq_dir0", hram_dq_dir, 0);
        check("rst_dq_dout0", hram_dq_dout, 0);
        check("rst_cmd_ready0", bus.cmd_ready, 0);
        check("rst_wr_ready0", bus.wr_ready, 0);
        check("rst_rd_valid0", bus.rd_valid, 0);
        check("rst_busy0", bus.busy, 0);
        check("rst_err0", bus.err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", bus.cmd_ready, 1);
        check("idle_ck", hram_ck, 0);

        data_q = '{8'hAB, 8'hCD};
        run_txn(1'b1, 32'h123, 0, 1'b0, -1, 0, 0, 1'b0);

        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_txn(1'b0, 32'h123, 1, 1'b0, -1, 0, 0, 1'b0);

        fill(6);
        run_txn(1'b1, $urandom, 2, 1'b1, -1, 0, 0, 1'b0);

        fill(8);
        run_txn(1'b1, $urandom, 3, 1'b0, 3, 3, 0, 1'b0);

        fill(8);
        run_txn(1'b0, $urandom, 3, 1'b0, -1, 0, 1, 1'b0);

        fill(512);
        run_txn(1'b1, $urandom, 255, 1'b0, -1, 0, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            bit w, dbl;
            int len, nb, s_at, s_len;
            w     = 1'($urandom_range(0, 1));
            dbl   = 1'($urandom_range(0, 1));
            len   = $urandom_range(0, 5);
            nb    = 2 * (len + 1);
            s_at  = -1;
            s_len = 0;
            if (w && $urandom_range(0, 1) == 1) begin
                s_at  = $urandom_range(0, nb - 1);
                s_len = $urandom_range(1, 4);
            end
            fill(nb);
            run_txn(w, $urandom, len, dbl, s_at, s_len, 0, 1'b0);
        end

`ifdef HRAM_SEQ_TIMEOUT_EN
        data_q.delete();
        run_txn(1'b0, $urandom, 0, 1'b0, -1, 0, 0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hram_seq.md
Name: hram_seq

Overview:
- HyperRAM transaction sequencer that sits directly upstream of the HRAM pin registers and SB_IO buffers; it replaces the static libretto ROM playback with command-driven sequences.
- Each clk cycle it drives one pin word {ck, cs, rwds_dir, rwds_dout, dq_dir, dq_dout}; ck toggles every cycle, so one DDR byte moves per clk cycle.
- Requests arrive on a valid/ready command port; write bytes stream in; captured read bytes stream out, typically to raspif endpoints.

Parameters:
- ADDR_W, 32: word-address width; must be ≥3 and ≤32.
- LEN_W, 8: burst length field width, in 16-bit words.
- LATENCY, 6: HyperRAM initial latency in CK periods.
- TIMEOUT, 255: read watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  sequencer idle and accepting.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  word address.
- cmd_len  in  LEN_W  word count minus 1.
- wr_valid / wr_ready  in / out  1 / 1  write byte handshake.
- wr_data  in  8  write byte; even byte index = high byte of word.
- rd_valid  out  1  one-cycle pulse per captured read byte; no backpressure.
- rd_data  out  8  captured read byte.
- busy  out  1  transaction in progress.
- err  out  1  sticky read-timeout flag; constant 0 without the optional feature.
- hram_ck, hram_cs, hram_rwds_dir, hram_rwds_dout, hram_dq_dir  out  1  to pin registers.
- hram_dq_dout  out  8  to pin registers.
- hram_rwds_din  in  1  from SB_IO.
- hram_dq_din  in  8  from SB_IO.

Behaviour:
- Reset (async, active-high): ck=0, cs=1, rwds_dir=0, rwds_dout=0, dq_dir=0, dq_dout=0, cmd_ready=0, wr_ready=0, rd_valid=0, busy=0, err=0, state=IDLE.
- State sequence: IDLE → CSLO → CA → LAT → (WR | RD) → CSHI → IDLE.
- IDLE:
  - cmd_ready=1 and ck held at 0.
  - Command is accepted on cmd_valid&&cmd_ready; addr, write and len are latched and busy rises next cycle.
- CSLO: one cycle; cs=0, dq_dir=1.
- CA: six cycles, ck toggling, dq_dout = CA[47:40] down to CA[7:0].
  - CA layout: [47]=!write, [46]=0, [45]=1 (linear burst), [44:16]=addr[ADDR_W-1:3] zero-extended, [15:3]=0, [2:0]=addr[2:0].
  - rwds_din is registered and sampled at CA byte index 2; if it is 1, latency is doubled.
- LAT:
  - dq_dir=0 after the last CA byte.
  - Wait 2*LATENCY clk cycles, or 4*LATENCY when doubled; ck keeps toggling.
- WR:
  - rwds_dir=1, dq_dir=1, rwds_dout=0 (no byte masking).
  - wr_ready=1 for one cycle per byte; total bytes = 2*(len+1).
  - If wr_valid=0, ck freezes at its current level, cs stays 0, and the byte is retried next cycle; no bytes are ever skipped.
- RD:
  - rwds_din and dq_din are registered; a change of registered rwds_din captures dq_din into rd_data, with rd_valid pulsing one cycle later.
  - ck toggles until 2*(len+1) bytes are captured.
- CSHI:
  - ck=0, cs=1, all directions 0.
  - Two cycles of CS-high hold before returning to IDLE.
- cmd_len=0 yields exactly 2 data bytes; the maximum is 2^LEN_W words.
- A byte counter of width LEN_W+1 must not wrap before the final byte.
- cmd_valid during busy is ignored; cmd_ready=0.
- Reset asserted mid-transaction returns all outputs to their reset values immediately; partial reads produce no further rd_valid.

Optional Feature:
- HRAM_SEQ_TIMEOUT_EN defined:
  - In RD, a counter clears on each captured byte and increments otherwise.
  - On reaching TIMEOUT it sets err (sticky until reset) and jumps to CSHI without emitting more rd_valid.
- Undefined: no watchdog, err tied 0, and RD waits indefinitely.

Decomposition:
- Shared package hram_pkg holds:
  - state enum {IDLE, CSLO, CA, LAT, WR, RD, CSHI};
  - CA bit-position constants (CA_RW=47, CA_AS=46, CA_BURST=45);
  - CA_BYTES=6 and CSHI_CYC=2.
- One sub-module, hram_rd_capture: input registering, rwds edge detect and rd_valid/rd_data generation.

Test Plan:
- Write, addr=0x123, len=0, bytes AB CD:
  - dq_dout shows 20 00 00 24 00 03;
  - after 12 LAT cycles, AB then CD with rwds_dir=1;
  - cs returns high, busy falls.
- Read, addr=0x123, len=1, model returns 11 22 33 44 on rwds toggles:
  - CA = A0 00 00 24 00 03;
  - exactly four rd_valid pulses with data 11, 22, 33, 44.
- Model drives rwds=1 during CA → LAT lasts 24 cycles instead of 12.
- Write with wr_valid deasserted for 3 cycles mid-burst:
  - ck frozen for those 3 cycles, no skipped byte;
  - total ck toggles unchanged.
- Reset pulse during RD after 1 byte:
  - cs=1, ck=0, dq_dir=0 immediately;
  - no further rd_valid; cmd_ready=1 after release.
- With HRAM_SEQ_TIMEOUT_EN and a model that never toggles rwds: err=1 after 255 RD cycles and cs deasserts.
